// File: rtl/regfile_hilo_pkg.sv
// Shared widths and wb_to_rf_bus field offsets for the architectural register state.
package regfile_hilo_pkg;
  localparam int REG_NUM         = 32;
  localparam int DATA_W          = 32;
  localparam int WB_TO_RF_WD     = 38;
  localparam int WB_TO_RF_BUS_WD = 103;

  localparam int RF_WDATA_LSB = 0;
  localparam int RF_WADDR_LSB = 32;
  localparam int RF_WE_BIT    = 37;
  localparam int DIV_RES_LSB  = 38;
  localparam int DIV_FLAG_BIT = 102;

  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair and its one-cycle write-pending flag.
// REGFILE_BYPASS_EN makes a same-cycle divider result visible on the read ports.
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_flag,
  input  logic [2*DATA_W-1:0] div_result,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  output logic              wr_pending
);
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic                pend_q;

  // {HI, LO} = {remainder, quotient}, matching the divider result layout
  assign hilo_d = div_flag ? div_result : hilo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo_q <= '0;
      pend_q <= 1'b0;
    end else begin
      hilo_q <= hilo_d;
      pend_q <= div_flag;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign {hi_rdata, lo_rdata} = hilo_d;
`else
  assign {hi_rdata, lo_rdata} = hilo_q;
`endif
  assign wr_pending = pend_q;
endmodule

// File: rtl/regfile_hilo.sv
// 32x32 GPR file plus HI/LO, written from the writeback bus, two combinational read ports.
// REGFILE_BYPASS_EN enables write-through of the in-flight writeback to the read ports.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int REG_NUM = regfile_hilo_pkg::REG_NUM,
  parameter int DATA_W  = regfile_hilo_pkg::DATA_W,
  parameter int BUS_W   = WB_TO_RF_BUS_WD,
  parameter int AW      = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [BUS_W-1:0]  wb_to_rf_bus,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  output logic              hilo_wr_pending
);
  localparam int NUM_RD = 2;

  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  div_flag;
  logic [2*DATA_W-1:0]   div_result;

  assign rf_wdata   = wb_to_rf_bus[RF_WDATA_LSB +: DATA_W];
  assign rf_waddr   = wb_to_rf_bus[RF_WADDR_LSB +: AW];
  assign rf_we      = wb_to_rf_bus[RF_WE_BIT];
  assign div_result = wb_to_rf_bus[DIV_RES_LSB +: 2*DATA_W];
  assign div_flag   = wb_to_rf_bus[DIV_FLAG_BIT];

  logic [REG_NUM-1:0][DATA_W-1:0] gpr_q;
  logic                           gpr_wr;

  // r0 is never written, so its storage stays at reset value
  assign gpr_wr = rf_we && (rf_waddr != ZERO_REG);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) gpr_q <= '0;
    else if (gpr_wr) gpr_q[rf_waddr] <= rf_wdata;
  end

  logic [NUM_RD-1:0][AW-1:0]     raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign raddr  = {raddr2, raddr1};
  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      rdata[p] = (raddr[p] == ZERO_REG) ? '0 : gpr_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (gpr_wr && (raddr[p] == rf_waddr)) rdata[p] = rf_wdata;
`endif
    end
  end

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk        (clk),
    .resetn     (resetn),
    .div_flag   (div_flag),
    .div_result (div_result),
    .hi_rdata   (hi_rdata),
    .lo_rdata   (lo_rdata),
    .wr_pending (hilo_wr_pending)
  );
endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: directed scenarios plus a randomized run against an array model.
module tb_regfile_hilo;
  logic        clk = 1'b0;
  logic        resetn;
  logic [102:0] bus;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata;
  logic        hilo_wr_pending;

  logic        b_flag;
  logic [63:0] b_res;
  logic        b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  assign bus = {b_flag, b_res, b_we, b_waddr, b_wdata};

  regfile_hilo dut (
    .clk(clk), .resetn(resetn), .wb_to_rf_bus(bus),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .hilo_wr_pending(hilo_wr_pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // architectural model
  logic [31:0] mdl_gpr [32];
  logic [31:0] mdl_hi, mdl_lo;
  logic        mdl_pend;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && b_we === 1'b1 && b_waddr != 0 && b_waddr == a) return b_wdata;
    return mdl_gpr[a];
  endfunction
  function automatic logic [31:0] exp_hi();
    return (BYP && b_flag === 1'b1) ? b_res[63:32] : mdl_hi;
  endfunction
  function automatic logic [31:0] exp_lo();
    return (BYP && b_flag === 1'b1) ? b_res[31:0] : mdl_lo;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_gpr[i] = 32'h0;
    mdl_hi = 0; mdl_lo = 0; mdl_pend = 0;
  endtask

  task automatic bus_idle();
    b_flag = 0; b_res = '0; b_we = 0; b_waddr = '0; b_wdata = '0;
  endtask

  // advance one posedge, committing the currently driven bus into the model
  task automatic tick();
    @(posedge clk);
    if (b_we === 1'b1 && b_waddr != 0) mdl_gpr[b_waddr] = b_wdata;
    if (b_flag === 1'b1) begin mdl_hi = b_res[63:32]; mdl_lo = b_res[31:0]; end
    mdl_pend = (b_flag === 1'b1);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0; bus_idle(); raddr1 = 5; raddr2 = 0; model_clear();
    #3;
    n_chk++; if ({rdata1, hi_rdata, lo_rdata, hilo_wr_pending} !== 97'h0) begin
      n_fail++; $display("FAIL reset_init: got r5=%h hi=%h lo=%h pend=%b want all 0", rdata1, hi_rdata, lo_rdata, hilo_wr_pending);
    end else n_pass++;
    @(negedge clk); resetn = 1;
    tick();
    b_we = 1; b_waddr = 5; b_wdata = 32'hDEADBEEF; b_flag = 1; b_res = 64'h0000_00AA_0000_00BB;
    tick();
    bus_idle();
    n_chk++; if (rdata1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_prewrite: r5=%h want deadbeef", rdata1);
    end else n_pass++;
    #2 resetn = 0; model_clear();
    #1;
    n_chk++; if ({rdata1, hi_rdata, lo_rdata, hilo_wr_pending} !== 97'h0) begin
      n_fail++; $display("FAIL reset_async: got r5=%h hi=%h lo=%h pend=%b want all 0", rdata1, hi_rdata, lo_rdata, hilo_wr_pending);
    end else n_pass++;
    // a write driven during reset is lost
    b_we = 1; b_waddr = 7; b_wdata = 32'h5555; 
    @(posedge clk); #1;
    n_chk++; raddr2 = 7; #1; if (rdata2 !== exp_rd(7)) begin
      n_fail++; $display("FAIL reset_wins: r7=%h want %h", rdata2, exp_rd(7));
    end else n_pass++;
    bus_idle();
    @(negedge clk); resetn = 1;
    tick();
  endtask

  task automatic test_r0();
    b_we = 1; b_waddr = 0; b_wdata = 32'hFFFFFFFF; raddr1 = 0; raddr2 = 0;
    #1;
    n_chk++; if (rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL r0_pre: got %h want 0", rdata1);
    end else n_pass++;
    tick();
    bus_idle();
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++; $display("FAIL r0_post: got %h/%h want 0", rdata1, rdata2);
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_dual();
    b_we = 1; b_waddr = 8; b_wdata = 32'h12345678; b_flag = 1; b_res = 64'h00000003_00000007;
    raddr1 = 8;
    tick();
    bus_idle();
    n_chk++; if (rdata1 !== 32'h12345678 || hi_rdata !== 32'd3 || lo_rdata !== 32'd7 || hilo_wr_pending !== 1'b1) begin
      n_fail++; $display("FAIL dual_write: r8=%h hi=%h lo=%h pend=%b want 12345678/3/7/1", rdata1, hi_rdata, lo_rdata, hilo_wr_pending);
    end else n_pass++;
    tick();
    n_chk++; if (hilo_wr_pending !== 1'b0 || hi_rdata !== 32'd3 || lo_rdata !== 32'd7) begin
      n_fail++; $display("FAIL dual_pend_drop: pend=%b hi=%h lo=%h want 0/3/7", hilo_wr_pending, hi_rdata, lo_rdata);
    end else n_pass++;
  endtask

  task automatic test_same_addr();
    logic [31:0] want;
    b_we = 1; b_waddr = 9; b_wdata = 32'h11;
    tick();
    b_wdata = 32'h22; raddr1 = 9; raddr2 = 9;
    b_flag = 1; b_res = 64'h00000044_00000055;
    #1;
    want = BYP ? 32'h22 : 32'h11;
    n_chk++; if (rdata1 !== want || rdata2 !== want) begin
      n_fail++; $display("FAIL same_addr_pre: got %h/%h want %h", rdata1, rdata2, want);
    end else n_pass++;
    want = BYP ? 32'h44 : mdl_hi;
    n_chk++; if (hi_rdata !== want || lo_rdata !== (BYP ? 32'h55 : mdl_lo)) begin
      n_fail++; $display("FAIL same_hilo_pre: hi=%h lo=%h want %h/%h", hi_rdata, lo_rdata, want, BYP ? 32'h55 : mdl_lo);
    end else n_pass++;
    tick();
    bus_idle(); #1;
    n_chk++; if (rdata1 !== 32'h22 || rdata2 !== 32'h22 || hi_rdata !== 32'h44 || lo_rdata !== 32'h55) begin
      n_fail++; $display("FAIL same_addr_post: got %h/%h hi=%h lo=%h want 22/22/44/55", rdata1, rdata2, hi_rdata, lo_rdata);
    end else n_pass++;
  endtask

  task automatic test_bubble();
    logic [31:0] hi0, lo0;
    for (int i = 1; i < 32; i++) begin
      b_we = 1; b_waddr = 5'(i); b_wdata = 32'(i);
      tick();
    end
    bus_idle();
    hi0 = mdl_hi; lo0 = mdl_lo;
    for (int c = 0; c < 10; c++) begin
      // idle variant with X in the data fields must also leave state alone
      if (c % 2 == 1) begin b_res = 'x; b_waddr = 'x; b_wdata = 'x; end
      else bus_idle();
      tick();
    end
    bus_idle();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
      n_chk++; if (rdata1 !== 32'(i) || rdata2 !== 32'(31 - i)) begin
        n_fail++; $display("FAIL bubble_gpr[%0d]: got %h/%h want %h/%h", i, rdata1, rdata2, 32'(i), 32'(31 - i));
      end else n_pass++;
    end
    n_chk++; if (hi_rdata !== hi0 || lo_rdata !== lo0 || hilo_wr_pending !== 1'b0) begin
      n_fail++; $display("FAIL bubble_hilo: hi=%h lo=%h pend=%b want %h/%h/0", hi_rdata, lo_rdata, hilo_wr_pending, hi0, lo0);
    end else n_pass++;
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_fail;
    for (int c = 0; c < 10000; c++) begin
      b_we    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: b_waddr = 5'd31;
        1: b_waddr = 5'd0;
        default: b_waddr = 5'($urandom);
      endcase
      b_wdata = $urandom;
      // runs of consecutive divider pulses
      b_flag  = ((c / 8) % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      b_res   = {$urandom, $urandom};
      raddr1  = ($urandom_range(0, 3) == 0) ? b_waddr : 5'($urandom);
      raddr2  = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      #1;
      n_chk++; if (rdata1 !== exp_rd(raddr1)) begin
        n_fail++; $display("FAIL rand_rd1 c=%0d a=%0d: got %h want %h", c, raddr1, rdata1, exp_rd(raddr1));
      end else n_pass++;
      n_chk++; if (rdata2 !== exp_rd(raddr2)) begin
        n_fail++; $display("FAIL rand_rd2 c=%0d a=%0d: got %h want %h", c, raddr2, rdata2, exp_rd(raddr2));
      end else n_pass++;
      n_chk++; if (hi_rdata !== exp_hi() || lo_rdata !== exp_lo()) begin
        n_fail++; $display("FAIL rand_hilo c=%0d: got %h/%h want %h/%h", c, hi_rdata, lo_rdata, exp_hi(), exp_lo());
      end else n_pass++;
      n_chk++; if (hilo_wr_pending !== mdl_pend) begin
        n_fail++; $display("FAIL rand_pend c=%0d: got %b want %b", c, hilo_wr_pending, mdl_pend);
      end else n_pass++;
      tick();
      if (n_fail - errs_before > 20) break;
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_r0();
    test_dual();
    test_same_addr();
    test_bubble();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
